// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out
// one bit per clock with a bit-valid strobe and a last-bit marker.
// A new word can be accepted on the last-bit cycle, so back-to-back words
// stream with no idle gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;
  logic             in_shift;
  logic             at_last;
  logic             accept;

  // Shift direction and output tap depend on bit order; the vacated end
  // always fills with zero.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      assign out_bit       = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      assign out_bit       = shreg_q[0];
    end
  endgenerate

  assign in_shift = (state_q == ST_SHIFT);
  assign at_last  = (cnt_q == CNT_LAST);

  // Ready comes from registered state only, so it never depends on din_valid.
  assign din_ready = ~in_shift | at_last;
  assign accept    = din_valid & din_ready;

  // Next-state logic: an accept always wins, including on the last-bit
  // cycle, which is what allows seamless back-to-back words.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = din;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end else if (in_shift) begin
      shreg_d = shreg_shifted;
      if (at_last) begin
        // Word finished with nothing queued behind it: park the counter at 0.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State, counter and shift register; reset drops any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Serial outputs are pure decodes of registers; data is gated to 0 when idle.
  assign sout_valid = in_shift;
  assign busy       = in_shift;
  assign sout_last  = in_shift & at_last;
  assign sout       = in_shift & out_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: table-driven per-cycle vectors on an
// MSB-first instance, a scoreboard of expected serial bits, and hand-written
// sequences for LSB-first order and mid-word reset.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] din_m, din_l;
  logic       dv_m, dv_l;
  logic       rdy_m, sout_m, sv_m, last_m, busy_m;
  logic       rdy_l, sout_l, sv_l, last_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] din;
    logic       dv;
    logic       sout;
    logic       sv;
    logic       last;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic b;
    logic last;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
    .sout(sout_m), .sout_valid(sv_m), .sout_last(last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
    .sout(sout_l), .sout_valid(sv_l), .sout_last(last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic v, input logic s,
                     input logic sv, input logic l, input logic r);
    vec_t e;
    e.din = d; e.dv = v; e.sout = s; e.sv = sv; e.last = l; e.rdy = r;
    vecs.push_back(e);
  endtask

  // Eight shifting rows for word w (MSB first); din/din_valid driven as dm/vm
  // on bits 0..6 and dl/vl on the last-bit cycle.
  task automatic add_shift(input logic [7:0] w, input logic [7:0] dm, input logic vm,
                           input logic [7:0] dl, input logic vl);
    for (int k = 0; k < 8; k++)
      add((k == 7) ? dl : dm, (k == 7) ? vl : vm, w[7-k], 1'b1, k == 7, k == 7);
  endtask

  task automatic push_word(input logic [7:0] w, input bit msb_first);
    sb_t e;
    for (int k = 0; k < 8; k++) begin
      e.b    = msb_first ? w[7-k] : w[k];
      e.last = (k == 7);
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: every valid serial bit must match the next expected one.
  always @(negedge clk) begin
    if (!reset && sv_m) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_bit", 32'(sv_m), 32'(0));
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_sout", 32'(sout_m), 32'(e.b));
        chk("sb_last", 32'(last_m), 32'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    reset = 1'b1;
    din_m = '0; dv_m = 1'b0;
    din_l = '0; dv_l = 1'b0;

    // Reset values while reset is held.
    #2;
    chk("rst_sout", 32'(sout_m), 32'(0));
    chk("rst_sv",   32'(sv_m),   32'(0));
    chk("rst_last", 32'(last_m), 32'(0));
    chk("rst_busy", 32'(busy_m), 32'(0));
    chk("rst_rdy",  32'(rdy_m),  32'(1));
    chk("rst_rdy_lsb", 32'(rdy_l), 32'(1));
    #10;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single word A5.
    add(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_shift(8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Back-to-back A5 then 3C with din_valid held high.
    add(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_shift(8'hA5, 8'h3C, 1'b1, 8'h3C, 1'b1);
    add_shift(8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Flow control: din changes after accept, a stray din_valid mid-word.
    add(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    w = 8'hA5;
    for (int k = 0; k < 8; k++)
      add(8'h00, k == 3, w[7-k], 1'b1, k == 7, k == 7);
    add(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Long idle stretch.
    for (int k = 0; k < 20; k++)
      add(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      din_m = vecs[i].din;
      dv_m  = vecs[i].dv;
      if (vecs[i].dv && vecs[i].rdy) push_word(vecs[i].din, 1'b1);
      @(negedge clk);
      chk($sformatf("row%0d_sout", i), 32'(sout_m), 32'(vecs[i].sout));
      chk($sformatf("row%0d_sv",   i), 32'(sv_m),   32'(vecs[i].sv));
      chk($sformatf("row%0d_busy", i), 32'(busy_m), 32'(vecs[i].sv));
      chk($sformatf("row%0d_last", i), 32'(last_m), 32'(vecs[i].last));
      chk($sformatf("row%0d_rdy",  i), 32'(rdy_m),  32'(vecs[i].rdy));
      $display("row %0d: din=%h dv=%b -> sout=%b sv=%b last=%b rdy=%b",
               i, vecs[i].din, vecs[i].dv, sout_m, sv_m, last_m, rdy_m);
      @(posedge clk); #1;
    end
    dv_m = 1'b0;

    // LSB-first instance, word 01.
    w = 8'h01;
    din_l = w; dv_l = 1'b1;
    @(negedge clk);
    chk("lsb_rdy_idle", 32'(rdy_l), 32'(1));
    @(posedge clk); #1;
    dv_l = 1'b0; din_l = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("lsb_bit%0d_sout", k), 32'(sout_l), 32'(w[k]));
      chk($sformatf("lsb_bit%0d_sv", k),   32'(sv_l),   32'(1));
      chk($sformatf("lsb_bit%0d_last", k), 32'(last_l), 32'(k == 7));
      $display("lsb bit %0d: sout=%b last=%b", k, sout_l, last_l);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lsb_after_sv", 32'(sv_l), 32'(0));
    chk("lsb_after_sout", 32'(sout_l), 32'(0));
    @(posedge clk); #1;

    // Mid-word reset while shifting FF.
    din_m = 8'hFF; dv_m = 1'b1;
    push_word(8'hFF, 1'b1);
    @(posedge clk); #1;
    dv_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ff_bit%0d_sout", k), 32'(sout_m), 32'(1));
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_sout", 32'(sout_m), 32'(0));
    chk("midrst_sv",   32'(sv_m),   32'(0));
    chk("midrst_last", 32'(last_m), 32'(0));
    chk("midrst_busy", 32'(busy_m), 32'(0));
    chk("midrst_rdy",  32'(rdy_m),  32'(1));
    $display("mid-word reset: sout=%b sv=%b last=%b busy=%b rdy=%b",
             sout_m, sv_m, last_m, busy_m, rdy_m);
    @(negedge clk); #2;
    reset = 1'b0;
    w = 8'h80;
    din_m = w; dv_m = 1'b1;
    push_word(w, 1'b1);
    @(posedge clk); #1;
    dv_m = 1'b0; din_m = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_bit%0d_sout", k), 32'(sout_m), 32'(w[7-k]));
      chk($sformatf("post_bit%0d_last", k), 32'(last_m), 32'(k == 7));
      $display("post-reset bit %0d: sout=%b last=%b", k, sout_m, last_m);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("post_idle_sv",  32'(sv_m),  32'(0));
    chk("post_idle_rdy", 32'(rdy_m), 32'(1));
    @(posedge clk); #1;

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
